imm_pack_loader: RTL and testbench
==================================

Name: imm_pack_loader

Overview:
- Inverse of the immediate extender: takes a base instruction word plus a signed immediate and format code, packs the immediate into I/S/B bit positions, and writes the finished word into instruction memory.
- Used by the on-FPGA program loader to build and store instruction streams at sequential word addresses.
- Range-checks every immediate and drops words whose immediate does not fit.
- Format code matches the extender's ImmSRC encoding.

Parameters:
- ADDR_W, 10, byte-address width of mem_addr and load_addr.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  pulse; sampled only in IDLE; begins a load session.
- load_addr  input  ADDR_W  session start byte address; bits [1:0] ignored (forced 0).
- in_valid  input  1  transfer offered.
- in_ready  output  1  transfer accepted when in_valid & in_ready.
- in_fmt  input  2  00=I, 01=S, 10=B, 11=raw (no packing).
- in_imm  input  32  signed immediate.
- in_base  input  32  instruction with opcode/rd/rs/funct fields; its immediate-field bits are ignored.
- in_last  input  1  marks final transfer of session.
- mem_we  output  1  write strobe, one cycle per word.
- mem_addr  output  ADDR_W  registered write byte address.
- mem_wdata  output  32  registered packed instruction.
- range_err  output  1  sticky: some immediate in this session was rejected.
- count  output  ADDR_W  words written this session; saturates at all-ones.
- done  output  1  one-cycle pulse on session end.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, mem_we, done, range_err = 0; mem_addr, mem_wdata, count, ptr = 0. Reset mid-session loses any pending write; no partial strobe.
- FSM states: IDLE, ACCEPT, WRITE.
- IDLE:
  - in_ready=0.
  - On load_start: ptr=load_addr with [1:0]=0, count=0, range_err=0, go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On handshake with a valid immediate: mem_wdata <= packed word, mem_addr <= ptr, go to WRITE.
  - On handshake with an invalid immediate: range_err <= 1, no write, ptr unchanged. Go to IDLE with done=1 next cycle if in_last, else stay in ACCEPT.
- WRITE:
  - mem_we=1 (combinational from state), in_ready=0.
  - Next edge: ptr += 4, modulo 2^ADDR_W, so it wraps to 0; count += 1 (saturating).
  - Go to IDLE with done=1 if the accepted transfer had in_last, else to ACCEPT.
- load_start is ignored outside IDLE.
- Throughput: one word per 2 cycles maximum.
- Latency: handshake edge to mem_we high = 1 cycle.
- Packing (all bits outside the listed immediate fields come from in_base):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - raw: word = in_base.
- Range rules:
  - I/S valid iff imm[31:11] all equal.
  - B valid iff imm[31:12] all equal and imm[0]=0.
  - raw always valid.
- done asserts in the first IDLE cycle after session end, for exactly one cycle.

Test Plan:
- I-type: load_addr=0x100; base=0x00000093, imm=0xFFFFFFFF, fmt=00, last=1 -> mem_we one cycle, addr=0x100, wdata=0xFFF00093; done next cycle; count=1.
- S/B-type: base=0x0020A023, imm=8, fmt=01 -> wdata=0x0020A423. Then base=0x00000063, imm=0xFFFFFFFC, fmt=10 -> wdata=0xFE000EE3 at addr+4.
- Range errors:
  - fmt=00, imm=0x800 -> no mem_we, range_err=1, ptr unchanged; next valid word lands at the same address.
  - fmt=10, imm=5 -> rejected the same way.
- Streaming/wrap: ADDR_W=8, load_addr=0xFE, three transfers with in_valid held high -> writes at 0xFC, 0x00, 0x04; in_ready low during every WRITE cycle; done after the third; count=3.
- Reset mid-write: drive rst_n=0 during a WRITE cycle -> mem_we, in_ready, mem_addr, mem_wdata, count all 0 immediately; FSM in IDLE; load_start during ACCEPT is ignored (ptr unchanged).

Source files
------------

// File: rtl/imm_pack_loader.sv
// rtl/imm_pack_loader.sv - packs signed immediates into I/S/B instruction fields and stores the words sequentially
module imm_pack_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_base,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              range_err,
    output logic [ADDR_W-1:0] count,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE} state_t;

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              range_err_q, range_err_d;
    logic              done_q, done_d;
    logic              last_q, last_d;

    logic [31:0] packed_word;
    logic        imm_ok;

    // Field placement mirrors the decoder's immediate extraction, so B drops imm[0].
    always_comb begin
        packed_word = in_base;
        imm_ok      = 1'b1;
        case (in_fmt)
            FMT_I: begin
                packed_word = {in_imm[11:0], in_base[19:0]};
                imm_ok      = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            FMT_S: begin
                packed_word = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
                imm_ok      = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            FMT_B: begin
                packed_word = {in_imm[12], in_imm[10:5], in_base[24:12],
                               in_imm[4:1], in_imm[11], in_base[6:0]};
                imm_ok      = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
            end
            default: begin
                packed_word = in_base;
                imm_ok      = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        range_err_d = range_err_q;
        last_d      = last_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    ptr_d       = load_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
                    count_d     = '0;
                    range_err_d = 1'b0;
                    state_d     = ACCEPT;
                end
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (imm_ok) begin
                        wdata_d = packed_word;
                        addr_d  = ptr_q;
                        last_d  = in_last;
                        state_d = WRITE;
                    end else begin
                        // Rejected word leaves ptr alone so the next good word fills the gap.
                        range_err_d = 1'b1;
                        if (in_last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                ptr_d   = ptr_q + {{(ADDR_W-3){1'b0}}, 3'b100};
                count_d = (&count_q) ? count_q : count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            count_q     <= '0;
            range_err_q <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            range_err_q <= range_err_d;
            done_q      <= done_d;
            last_q      <= last_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign range_err = range_err_q;
    assign count     = count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_imm_pack_loader.sv
// tb/tb_imm_pack_loader.sv - directed vector bench for imm_pack_loader
module tb_imm_pack_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [9:0]  load_addr;
    logic        in_valid;
    logic [1:0]  in_fmt;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        in_last;

    logic        in_ready, mem_we, range_err, done;
    logic [9:0]  mem_addr, count;
    logic [31:0] mem_wdata;

    logic [7:0]  load_addr8;
    logic        in_ready8, mem_we8, range_err8, done8;
    logic [7:0]  mem_addr8, count8;
    logic [31:0] mem_wdata8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign load_addr8 = load_addr[7:0];

    imm_pack_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_addr(load_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_imm(in_imm),
        .in_base(in_base), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .range_err(range_err), .count(count), .done(done)
    );

    imm_pack_loader #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_addr(load_addr8),
        .in_valid(in_valid), .in_ready(in_ready8), .in_fmt(in_fmt), .in_imm(in_imm),
        .in_base(in_base), .in_last(in_last), .mem_we(mem_we8), .mem_addr(mem_addr8),
        .mem_wdata(mem_wdata8), .range_err(range_err8), .count(count8), .done(done8)
    );

    typedef struct {
        logic        start;
        logic [9:0]  addr;
        logic [1:0]  fmt;
        logic [31:0] imm;
        logic [31:0] base;
        logic        last;
        logic        ok;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic start_session(input logic [9:0] a);
        load_addr  = a;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("start_in_ready", {31'b0, in_ready}, 32'd1);
        chk("start_count", {22'b0, count}, 32'd0);
        chk("start_range_err", {31'b0, range_err}, 32'd0);
    endtask

    initial begin
        logic [9:0] exp_ptr;
        int         exp_cnt;
        logic       exp_err;
        int         widx;
        logic [7:0] wrap_addr[3];

        vecs[0]  = '{1'b1, 10'h100, 2'd0, 32'hFFFFFFFF, 32'h00000093, 1'b1, 1'b1, 32'hFFF00093};
        vecs[1]  = '{1'b1, 10'h200, 2'd1, 32'h00000008, 32'h0020A023, 1'b0, 1'b1, 32'h0020A423};
        vecs[2]  = '{1'b0, 10'h000, 2'd2, 32'hFFFFFFFC, 32'h00000063, 1'b0, 1'b1, 32'hFE000EE3};
        vecs[3]  = '{1'b0, 10'h000, 2'd0, 32'h00000800, 32'h00000013, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 10'h000, 2'd0, 32'h000007FF, 32'h00000013, 1'b0, 1'b1, 32'h7FF00013};
        vecs[5]  = '{1'b0, 10'h000, 2'd2, 32'h00000005, 32'h00000063, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 10'h000, 2'd0, 32'hFFFFF800, 32'h00000013, 1'b0, 1'b1, 32'h80000013};
        vecs[7]  = '{1'b0, 10'h000, 2'd3, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1, 32'h12345678};
        vecs[8]  = '{1'b0, 10'h000, 2'd2, 32'h00000FFE, 32'h00000000, 1'b0, 1'b1, 32'h7E000F80};
        vecs[9]  = '{1'b0, 10'h000, 2'd1, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h01FFF07F};
        vecs[10] = '{1'b0, 10'h000, 2'd2, 32'h00001000, 32'h00000063, 1'b1, 1'b0, 32'h0};

        rst_n = 1'b0; load_start = 1'b0; load_addr = '0; in_valid = 1'b0;
        in_fmt = '0; in_imm = '0; in_base = '0; in_last = 1'b0;
        exp_ptr = '0; exp_cnt = 0; exp_err = 1'b0;
        repeat (2) step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_range_err", {31'b0, range_err}, 32'd0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_count", {22'b0, count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].start) begin
                start_session(vecs[i].addr);
                exp_ptr = vecs[i].addr & 10'h3FC;
                exp_cnt = 0;
                exp_err = 1'b0;
            end
            in_fmt   = vecs[i].fmt;
            in_imm   = vecs[i].imm;
            in_base  = vecs[i].base;
            in_last  = vecs[i].last;
            in_valid = 1'b1;
            wait_ready();
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].ok});
            if (vecs[i].ok) begin
                chk($sformatf("v%0d_addr", i), {22'b0, mem_addr}, {22'b0, exp_ptr});
                chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
                chk($sformatf("v%0d_ready_in_write", i), {31'b0, in_ready}, 32'd0);
                exp_ptr = exp_ptr + 10'd4;
                exp_cnt++;
                step();
                chk($sformatf("v%0d_we_one_cycle", i), {31'b0, mem_we}, 32'd0);
            end else begin
                exp_err = 1'b1;
            end
            chk($sformatf("v%0d_range_err", i), {31'b0, range_err}, {31'b0, exp_err});
            chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, vecs[i].last});
            chk($sformatf("v%0d_count", i), {22'b0, count}, exp_cnt);
            chk($sformatf("v%0d_ready_after", i), {31'b0, in_ready}, {31'b0, ~vecs[i].last});
            if (vecs[i].last) begin
                step();
                chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
            end
        end

        // Streaming with in_valid held high on the 8-bit instance, pointer wraps past 0xFC.
        wrap_addr[0] = 8'hFC; wrap_addr[1] = 8'h00; wrap_addr[2] = 8'h04;
        start_session(10'h0FE);
        in_fmt = 2'd3; in_base = 32'hA0; in_last = 1'b0; in_valid = 1'b1;
        widx = 0;
        for (int c = 0; c < 20 && widx < 3; c++) begin
            step();
            if (mem_we8) begin
                chk($sformatf("wrap%0d_addr", widx), {24'b0, mem_addr8}, {24'b0, wrap_addr[widx]});
                chk($sformatf("wrap%0d_wdata", widx), mem_wdata8, 32'hA0 + widx);
                chk($sformatf("wrap%0d_ready", widx), {31'b0, in_ready8}, 32'd0);
                widx++;
                in_base = 32'hA0 + widx;
                in_last = (widx == 2);
                if (widx == 3) in_valid = 1'b0;
            end
        end
        chk("wrap_writes", widx, 32'd3);
        step();
        chk("wrap_done", {31'b0, done8}, 32'd1);
        chk("wrap_count", {24'b0, count8}, 32'd3);
        chk("wrap_ready_idle", {31'b0, in_ready8}, 32'd0);
        in_last = 1'b0;
        step();

        // Asynchronous reset while a word is in WRITE.
        start_session(10'h100);
        in_fmt = 2'd0; in_imm = 32'd1; in_base = 32'h13; in_last = 1'b0; in_valid = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
        chk("midrst_pre_we", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", {31'b0, mem_we}, 32'd0);
        chk("midrst_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_addr", {22'b0, mem_addr}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        chk("midrst_count", {22'b0, count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("midrst_idle_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_idle_we", {31'b0, mem_we}, 32'd0);

        // load_start during ACCEPT must not move the pointer.
        start_session(10'h100);
        load_addr  = 10'h300;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("ignore_start_ready", {31'b0, in_ready}, 32'd1);
        in_fmt = 2'd0; in_imm = 32'd1; in_base = 32'h13; in_last = 1'b1; in_valid = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
        chk("ignore_start_addr", {22'b0, mem_addr}, 32'h100);
        chk("ignore_start_wdata", mem_wdata, 32'h00100013);
        step();
        chk("ignore_start_done", {31'b0, done}, 32'd1);
        chk("ignore_start_count", {22'b0, count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
